// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of a single-ported RAM.
// Each transaction runs IDLE -> WAIT -> DONE. The granted request is latched
// so the RAM-side address and data stay stable while the RAM works on it.
// A WAIT-cycle counter forces completion when the RAM never answers, and a
// sticky flag records that this happened.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64   // legal range 2..255
) (
  input  logic          clk,
  input  logic          reset,

  input  logic [AW-1:0] c0Address,
  input  logic [AW-1:0] c1Address,
  input  logic [DW-1:0] c0WData,
  input  logic [DW-1:0] c1WData,
  input  logic          c0ReadReq,
  input  logic          c0WriteReq,
  input  logic          c1ReadReq,
  input  logic          c1WriteReq,

  output logic [DW-1:0] c0RData,
  output logic [DW-1:0] c1RData,
  output logic          c0ReadAck,
  output logic          c0WriteAck,
  output logic          c1ReadAck,
  output logic          c1WriteAck,

  output logic [AW-1:0] ramAddress,
  output logic [DW-1:0] ramOut,
  output logic          readReq,
  output logic          writeReq,
  input  logic [DW-1:0] ramValue,
  input  logic          readAck,
  input  logic          writeAck,

  output logic          busy,
  output logic          grant,
  output logic          timeoutErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arbState;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  arbState       state;
  arbState       nextState;

  logic          pointer;      // client that wins when both request
  logic          opWrite;      // latched operation of the current transaction
  logic [7:0]    waitCnt;      // WAIT cycles elapsed in the current transaction
  logic [7:0]    waitCntInc;

  logic          c0Req;
  logic          c1Req;
  logic          anyReq;
  logic          pickClient;
  logic          pickWrite;
  logic [AW-1:0] pickAddress;
  logic [DW-1:0] pickWData;

  logic          ramHit;       // RAM ack of the type the transaction expects
  logic          timeoutHit;   // this WAIT cycle is the last one allowed
  logic          doGrant;
  logic          doFinish;

  assign c0Req  = c0ReadReq | c0WriteReq;
  assign c1Req  = c1ReadReq | c1WriteReq;
  assign anyReq = c0Req | c1Req;

  // Choose the client to serve: sole requester wins, a tie goes to the pointer.
  // A client raising both read and write is served as a write.
  // NOTE: every combinational output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    pickClient = 1'b0;
    if (c0Req && c1Req) begin
      pickClient = pointer;
    end else if (c1Req) begin
      pickClient = 1'b1;
    end
    pickWrite   = pickClient ? c1WriteReq : c0WriteReq;
    pickAddress = pickClient ? c1Address  : c0Address;
    pickWData   = pickClient ? c1WData    : c0WData;
  end

  assign waitCntInc = waitCnt + 8'd1;
  assign ramHit     = opWrite ? writeAck : readAck;
  assign timeoutHit = (waitCntInc == TIMEOUT_CNT);

  // Next-state logic; also flags the grant and completion events for the datapath.
  always_comb begin
    nextState = state;
    doGrant   = 1'b0;
    doFinish  = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          nextState = WAIT;
          doGrant   = 1'b1;
        end
      end
      WAIT: begin
        // An ack of the other type never matches ramHit, so it is ignored here.
        if (ramHit || timeoutHit) begin
          nextState = DONE;
          doFinish  = 1'b1;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Request latch, RAM request pulses and the WAIT counter.
  // NOTE: the latch is reset even though it only matters while busy, because
  // ramAddress, ramOut and grant must all read 0 during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= 1'b0;
      opWrite    <= 1'b0;
      ramAddress <= '0;
      ramOut     <= '0;
      readReq    <= 1'b0;
      writeReq   <= 1'b0;
      waitCnt    <= 8'd0;
    end else begin
      readReq  <= 1'b0;
      writeReq <= 1'b0;
      if (doGrant) begin
        grant      <= pickClient;
        opWrite    <= pickWrite;
        ramAddress <= pickAddress;
        ramOut     <= pickWData;
        readReq    <= ~pickWrite;
        writeReq   <= pickWrite;
        waitCnt    <= 8'd0;
      end else if (state == WAIT) begin
        waitCnt <= waitCntInc;
      end
    end
  end

  // Client completion: one-cycle ack, read data capture, sticky timeout flag,
  // and the round-robin pointer flip on the way back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c0ReadAck  <= 1'b0;
      c0WriteAck <= 1'b0;
      c1ReadAck  <= 1'b0;
      c1WriteAck <= 1'b0;
      c0RData    <= '0;
      c1RData    <= '0;
      timeoutErr <= 1'b0;
      pointer    <= 1'b0;
    end else begin
      c0ReadAck  <= 1'b0;
      c0WriteAck <= 1'b0;
      c1ReadAck  <= 1'b0;
      c1WriteAck <= 1'b0;
      if (doFinish) begin
        // A forced read completion returns zero rather than whatever is on ramValue.
        case ({grant, opWrite})
          2'b00: begin
            c0ReadAck <= 1'b1;
            c0RData   <= ramHit ? ramValue : '0;
          end
          2'b01: c0WriteAck <= 1'b1;
          2'b10: begin
            c1ReadAck <= 1'b1;
            c1RData   <= ramHit ? ramValue : '0;
          end
          default: c1WriteAck <= 1'b1;
        endcase
        if (!ramHit) begin
          timeoutErr <= 1'b1;
        end
      end
      if (state == DONE) begin
        pointer <= ~pointer;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic with a noisy RAM and random resets.
// A transaction-level model predicts every output on every cycle.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] c0Address, c1Address;
  logic [DW-1:0] c0WData, c1WData;
  logic          c0ReadReq, c0WriteReq, c1ReadReq, c1WriteReq;
  logic [DW-1:0] c0RData, c1RData;
  logic          c0ReadAck, c0WriteAck, c1ReadAck, c1WriteAck;
  logic [AW-1:0] ramAddress;
  logic [DW-1:0] ramOut;
  logic          readReq, writeReq;
  logic [DW-1:0] ramValue;
  logic          readAck, writeAck;
  logic          busy, grant, timeoutErr;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .c0Address(c0Address), .c1Address(c1Address),
    .c0WData(c0WData), .c1WData(c1WData),
    .c0ReadReq(c0ReadReq), .c0WriteReq(c0WriteReq),
    .c1ReadReq(c1ReadReq), .c1WriteReq(c1WriteReq),
    .c0RData(c0RData), .c1RData(c1RData),
    .c0ReadAck(c0ReadAck), .c0WriteAck(c0WriteAck),
    .c1ReadAck(c1ReadAck), .c1WriteAck(c1WriteAck),
    .ramAddress(ramAddress), .ramOut(ramOut),
    .readReq(readReq), .writeReq(writeReq),
    .ramValue(ramValue), .readAck(readAck), .writeAck(writeAck),
    .busy(busy), .grant(grant), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction granted at edge g completes at the first later edge that
  // sees the matching RAM ack, or at edge g+TO. The arbiter is busy through
  // the completion edge and can grant again two edges after it.
  int            edgeNo;
  int            gEdge;
  int            doneEdge;
  int            freeAt;
  bit            txnOpen, mClient, mWrite, mPtr, mErr;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWData;
  logic [DW-1:0] mRData [2];
  bit            eReadReq, eWriteReq, eBusy;
  bit            eRAck [2];
  bit            eWAck [2];

  function automatic void modelReset();
    txnOpen   = 0; mClient = 0; mWrite = 0; mPtr = 0; mErr = 0;
    mAddr     = '0; mWData = '0; mRData[0] = '0; mRData[1] = '0;
    eReadReq  = 0; eWriteReq = 0; eBusy = 0;
    eRAck[0]  = 0; eRAck[1] = 0; eWAck[0] = 0; eWAck[1] = 0;
    doneEdge  = -1;
    freeAt    = 0;
  endfunction

  task automatic compareAll();
    check("busy",       busy,       eBusy);
    check("readReq",    readReq,    eReadReq);
    check("writeReq",   writeReq,   eWriteReq);
    check("c0ReadAck",  c0ReadAck,  eRAck[0]);
    check("c1ReadAck",  c1ReadAck,  eRAck[1]);
    check("c0WriteAck", c0WriteAck, eWAck[0]);
    check("c1WriteAck", c1WriteAck, eWAck[1]);
    check("c0RData",    c0RData,    mRData[0]);
    check("c1RData",    c1RData,    mRData[1]);
    check("timeoutErr", timeoutErr, mErr);
    if (eBusy || !reset) begin
      check("grant",      grant,      mClient);
      check("ramAddress", ramAddress, mAddr);
      check("ramOut",     ramOut,     mWData);
    end
  endtask

  // Model update at each posedge from the sampled inputs; compare at negedge.
  initial begin
    bit            r0, w0, r1, w1, sRAck, sWAck, hit;
    logic [DW-1:0] sVal;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    edgeNo = 0;
    modelReset();
    forever begin
      @(posedge clk);
      edgeNo++;
      r0 = c0ReadReq; w0 = c0WriteReq; r1 = c1ReadReq; w1 = c1WriteReq;
      a0 = c0Address; a1 = c1Address; d0 = c0WData; d1 = c1WData;
      sRAck = readAck; sWAck = writeAck; sVal = ramValue;
      eReadReq = 0; eWriteReq = 0;
      eRAck[0] = 0; eRAck[1] = 0; eWAck[0] = 0; eWAck[1] = 0;
      if (!reset) begin
        modelReset();
      end else if (txnOpen) begin
        hit = mWrite ? sWAck : sRAck;
        if (hit || (edgeNo - gEdge) == TO) begin
          if (mWrite) begin
            eWAck[mClient] = 1;
          end else begin
            eRAck[mClient]  = 1;
            mRData[mClient] = hit ? sVal : '0;
          end
          if (!hit) mErr = 1;
          txnOpen  = 0;
          doneEdge = edgeNo;
          freeAt   = edgeNo + 2;
          mPtr     = !mPtr;
        end
      end else if (edgeNo >= freeAt && (r0 || w0 || r1 || w1)) begin
        mClient   = ((r0 || w0) && (r1 || w1)) ? mPtr : (r1 || w1);
        mWrite    = mClient ? w1 : w0;
        mAddr     = mClient ? a1 : a0;
        mWData    = mClient ? d1 : d0;
        eReadReq  = !mWrite;
        eWriteReq = mWrite;
        txnOpen   = 1;
        gEdge     = edgeNo;
      end
      eBusy = txnOpen || (doneEdge == edgeNo);
      @(negedge clk);
      if (!reset) modelReset();
      compareAll();
    end
  end

  // ---------------- stimulus: clients and RAM ----------------
  logic [DW-1:0] mem [256];

  bit            cHold [2];
  int            cOp [2];           // 0 read, 1 write, 2 read+write
  logic [AW-1:0] cAddr [2];
  logic [DW-1:0] cData [2];
  bit            cNewValid [2];
  int            cNewOp [2];
  logic [AW-1:0] cNewAddr [2];
  logic [DW-1:0] cNewData [2];
  bit            cRandom;
  int            autoBudget;

  bit            ramAuto, ramNever, ramNoise, ramLatRand, ramPending, ramOpW;
  int            ramLat, ramCount;
  logic [7:0]    ramA;
  logic [DW-1:0] ramD;

  int            stepNo, rdPulses, wrPulses, lastReqStep, lastAckStep;
  int            rAckCnt [2];
  int            wAckCnt [2];
  logic [AW-1:0] lastReqAddr;
  logic [DW-1:0] lastRData [2];
  int            ackLog [$];
  int            grantLog [$];
  int            reqSteps [$];

  task automatic driveClients();
    c0ReadReq  = cHold[0] && (cOp[0] != 1);
    c0WriteReq = cHold[0] && (cOp[0] != 0);
    c1ReadReq  = cHold[1] && (cOp[1] != 1);
    c1WriteReq = cHold[1] && (cOp[1] != 0);
    c0Address  = cAddr[0];  c1Address = cAddr[1];
    c0WData    = cData[0];  c1WData   = cData[1];
  endtask

  task automatic ramRespond();
    if (ramOpW) begin
      mem[ramA] = ramD;
      writeAck  = 1;
    end else begin
      ramValue = mem[ramA];
      readAck  = 1;
    end
    ramPending = 0;
  endtask

  task automatic request(input int i, input int op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cNewValid[i] = 1; cNewOp[i] = op; cNewAddr[i] = a; cNewData[i] = d;
  endtask

  task automatic clearStats();
    rdPulses = 0; wrPulses = 0;
    rAckCnt[0] = 0; rAckCnt[1] = 0; wAckCnt[0] = 0; wAckCnt[1] = 0;
    ackLog.delete(); grantLog.delete(); reqSteps.delete();
  endtask

  // One clock: observe DUT just after the edge, then update RAM and clients.
  task automatic stepCycle();
    bit gotAck;
    @(posedge clk);
    #1;
    stepNo++;
    readAck  = 0;
    writeAck = 0;
    if (ramNoise) ramValue = $urandom;
    if (readReq)  rdPulses++;
    if (writeReq) wrPulses++;
    if (readReq || writeReq) begin
      lastReqStep = stepNo;
      lastReqAddr = ramAddress;
      grantLog.push_back(int'(grant));
      reqSteps.push_back(stepNo);
    end
    if (!reset) begin
      ramPending = 0;
    end else if (ramAuto) begin
      if (ramPending) begin
        ramCount--;
        if (ramCount <= 0) ramRespond();
      end
      if (readReq || writeReq) begin
        ramOpW     = writeReq;
        ramA       = ramAddress[7:0];
        ramD       = ramOut;
        ramPending = !ramNever;
        ramCount   = ramLatRand ? int'($urandom_range(0, 10)) : ramLat;
        if (ramPending && ramCount == 0) ramRespond();
      end
      if (ramNoise && !readAck && !writeAck && $urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) readAck = 1;
        else writeAck = 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      gotAck = (i == 0) ? (c0ReadAck || c0WriteAck) : (c1ReadAck || c1WriteAck);
      if (!reset) begin
        cHold[i] = 0;
        cNewValid[i] = 0;
      end else if (cHold[i] && gotAck) begin
        cHold[i] = 0;
        if ((i == 0) ? c0ReadAck : c1ReadAck) rAckCnt[i]++;
        else wAckCnt[i]++;
        ackLog.push_back(i);
        lastAckStep  = stepNo;
        lastRData[i] = (i == 0) ? c0RData : c1RData;
      end else if (!cHold[i]) begin
        if (cNewValid[i]) begin
          cHold[i] = 1; cOp[i] = cNewOp[i]; cAddr[i] = cNewAddr[i]; cData[i] = cNewData[i];
          cNewValid[i] = 0;
        end else if (autoBudget > 0) begin
          cHold[i] = 1; cOp[i] = 0; cAddr[i] = AW'(16 * (i + 1)); cData[i] = '0;
          autoBudget--;
        end else if (cRandom && $urandom_range(0, 2) == 0) begin
          cHold[i] = 1;
          cOp[i]   = int'($urandom_range(0, 2));
          cAddr[i] = AW'($urandom);
          cData[i] = $urandom;
        end
      end
    end
    driveClients();
  endtask

  task automatic runUntilIdle(input string name, input int maxCycles);
    int n;
    n = 0;
    do begin
      stepCycle();
      n++;
    end while ((cHold[0] || cHold[1] || cNewValid[0] || cNewValid[1] || autoBudget > 0 || busy)
               && n < maxCycles);
    check({name, "_completed_in_budget"}, (n < maxCycles), 1'b1);
  endtask

  task automatic pulseReset();
    reset = 0;
    stepCycle();
    stepCycle();
    reset = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h1234_5678;
    reset = 0;
    readAck = 0; writeAck = 0; ramValue = '0;
    for (int i = 0; i < 2; i++) begin
      cHold[i] = 0; cOp[i] = 0; cAddr[i] = '0; cData[i] = '0; cNewValid[i] = 0;
      lastRData[i] = '0;
    end
    cRandom = 0; autoBudget = 0;
    ramAuto = 1; ramNever = 0; ramNoise = 0; ramLatRand = 0; ramLat = 2; ramPending = 0;
    stepNo = 0; lastReqStep = 0; lastAckStep = 0;
    clearStats();
    driveClients();

    // Reset state
    repeat (3) stepCycle();
    check("rst_busy", busy, 1'b0);
    check("rst_c0RData", c0RData, '0);
    check("rst_ramAddress", ramAddress, '0);
    reset = 1;

    // c0 read of a preloaded word
    clearStats();
    request(0, 0, 16'h0010, '0);
    runUntilIdle("rd10", 40);
    check("rd10_readReq_pulses", rdPulses, 1);
    check("rd10_writeReq_pulses", wrPulses, 0);
    check("rd10_ramAddress", lastReqAddr, 16'h0010);
    check("rd10_c0_acks", rAckCnt[0], 1);
    check("rd10_c1_acks", rAckCnt[1] + wAckCnt[1], 0);
    check("rd10_c0RData", lastRData[0], 32'h1234_5678);
    check("rd10_latency", lastAckStep - lastReqStep, 3);

    // c1 write then c0 read-back
    clearStats();
    request(1, 1, 16'h0020, 32'hDEAD_BEEF);
    runUntilIdle("wr20", 40);
    check("wr20_c1_write_acks", wAckCnt[1], 1);
    check("wr20_c1_read_acks", rAckCnt[1], 0);
    request(0, 0, 16'h0020, '0);
    runUntilIdle("rb20", 40);
    check("rb20_c0RData", lastRData[0], 32'hDEAD_BEEF);
    check("rb20_c1RData_untouched", c1RData, '0);

    // Simultaneous reads straight after reset
    pulseReset();
    clearStats();
    request(0, 0, 16'h0010, '0);
    request(1, 0, 16'h0020, '0);
    runUntilIdle("both", 60);
    check("both_ack_count", ackLog.size(), 2);
    check("both_first_client", ackLog[0], 0);
    check("both_second_client", ackLog[1], 1);
    check("both_second_grant", grantLog[1], 1);
    check("both_c0RData", lastRData[0], 32'h1234_5678);
    check("both_c1RData", lastRData[1], 32'hDEAD_BEEF);
    clearStats();
    request(0, 0, 16'h0010, '0);
    request(1, 0, 16'h0020, '0);
    runUntilIdle("both2", 60);
    check("both2_pointer_back_to_c0", ackLog[0], 0);

    // RAM never answers: forced completion
    clearStats();
    ramNever = 1;
    request(0, 0, 16'h0010, '0);
    runUntilIdle("tmo", 40);
    check("tmo_c0_acks", rAckCnt[0], 1);
    check("tmo_wait_cycles", lastAckStep - lastReqStep, 8);
    check("tmo_c0RData", lastRData[0], '0);
    check("tmo_err_set", timeoutErr, 1'b1);
    ramNever = 0;
    request(1, 1, 16'h0030, 32'h1111_2222);
    runUntilIdle("tmo_after", 40);
    check("tmo_after_write_ack", wAckCnt[1], 1);
    check("tmo_err_sticky", timeoutErr, 1'b1);
    reset = 0;
    stepCycle();
    check("tmo_err_cleared", timeoutErr, 1'b0);
    reset = 1;

    // Reset in WAIT, then a stale RAM ack
    clearStats();
    ramAuto = 0;
    request(0, 0, 16'h0040, '0);
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (!readReq && n < 10);
    check("rstw_grant_seen", readReq, 1'b1);
    stepCycle();
    reset = 0;
    stepCycle();
    reset = 1;
    stepCycle();
    stepCycle();
    readAck  = 1;
    ramValue = 32'hA5A5_A5A5;
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      check("rstw_no_c0ReadAck", c0ReadAck, 1'b0);
      check("rstw_idle", busy, 1'b0);
      check("rstw_c0RData", c0RData, '0);
    end
    check("rstw_ack_count", rAckCnt[0], 0);
    ramAuto = 1;

    // Both clients keep reading for 20 transactions
    clearStats();
    autoBudget = 20;
    runUntilIdle("alt", 300);
    check("alt_c0_acks", rAckCnt[0], 10);
    check("alt_c1_acks", rAckCnt[1], 10);
    for (int k = 0; k < 20; k++) check($sformatf("alt_order_%0d", k), ackLog[k], k % 2);
    for (int k = 1; k < 20; k++) check($sformatf("alt_period_%0d", k), reqSteps[k] - reqSteps[k-1], 5);

    // Randomized traffic against the model
    cRandom = 1; ramNoise = 1; ramLatRand = 1;
    for (int k = 0; k < 4000; k++) begin
      stepCycle();
      if (!reset) reset = 1;
      else if ($urandom_range(0, 399) == 0) reset = 0;
      if (ramNever) begin
        if ($urandom_range(0, 29) == 0) ramNever = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        ramNever = 1;
      end
    end
    reset = 1; cRandom = 0; ramNoise = 0; ramLatRand = 0; ramNever = 0;
    runUntilIdle("drain", 100);
    repeat (2) stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning maximum WAIT cycles before forced completion (legal range 2..255).
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 c0Address / c1Address  in  AW each  client 0/1 request address.
REQ-007 c0WData / c1WData  in  DW each  client 0/1 write data.
REQ-008 c0ReadReq, c0WriteReq, c1ReadReq, c1WriteReq  in  1 each  level request, held until the matching ack.
REQ-009 c0RData / c1RData  out  DW each  read return data, valid while the matching ReadAck is 1.
REQ-010 c0ReadAck, c0WriteAck, c1ReadAck, c1WriteAck  out  1 each  one-cycle completion pulse.
REQ-011 ramAddress  out  AW  shared RAM address; ramOut  out  DW  shared RAM write data.
REQ-012 readReq, writeReq  out  1 each  RAM request pulses.
REQ-013 ramValue  in  DW  RAM read data; readAck, writeAck  in  1 each  RAM completion pulses.
REQ-014 busy  out  1  state != IDLE; grant  out  1  index of client owning the RAM (valid when busy).
REQ-015 timeoutErr  out  1  sticky; set on any forced completion.

Function
REQ-016 The block SHALL implement states IDLE, WAIT, DONE.
REQ-017 IDLE: a client is requesting when its ReadReq or WriteReq is 1; if none, remain IDLE.
REQ-018 IDLE, one requester: grant it; both: grant the client indicated by the round-robin pointer.
REQ-019 On grant: latch address, write data, op and client index; drive ramAddress/ramOut from the latch; pulse readReq or writeReq for exactly one cycle (next cycle); go WAIT.
REQ-020 A client with ReadReq and WriteReq both 1 SHALL be served as a write.
REQ-021 ramAddress/ramOut SHALL stay stable from grant until return to IDLE.
REQ-022 WAIT: on readAck (read op) capture ramValue into the granted client's RData and pulse its ReadAck; on writeAck (write op) pulse its WriteAck; go DONE.
REQ-023 WAIT: RAM ack of the wrong type SHALL be ignored.
REQ-024 WAIT: 8-bit counter, cleared on grant, increments each WAIT cycle; when it reaches TIMEOUT with no ack, pulse the client ack (RData = 0 for reads), set timeoutErr, go DONE.
REQ-025 DONE: deassert all client acks; toggle pointer to the other client; go IDLE (one dead cycle lets the client drop its request).
REQ-026 RAM acks arriving in IDLE or DONE SHALL be ignored.
REQ-027 Client RData SHALL hold its last value between reads; only the granted client's RData changes.
REQ-028 Latency with a RAM acking two cycles after the request pulse: client ack high on the 3rd edge after grant; 5 cycles per transaction including the IDLE re-sample.
REQ-029 Under continuous requests from both clients, grants SHALL strictly alternate; no client starves beyond one transaction.

Reset
REQ-030 reset = 0 SHALL asynchronously force state IDLE, pointer = client 0, counter = 0, timeoutErr = 0, and all outputs (acks, req pulses, RData, ramAddress, ramOut, busy, grant) to 0.
REQ-031 Reset mid-transaction SHALL abandon it with no client ack; a late RAM ack after reset release SHALL be ignored.
REQ-032 After reset release, the first grant SHALL occur on the first posedge at which a request is sampled.

Verification
REQ-033 RAM[0x10] = 0x12345678; c0 read 0x10 -> one readReq pulse with ramAddress 0x10, c0ReadAck one cycle with c0RData 0x12345678, no c1 acks.
REQ-034 c1 write 0xDEADBEEF to 0x20, then c0 read 0x20 -> c1WriteAck pulse, then c0RData 0xDEADBEEF.
REQ-035 c0 and c1 read simultaneously right after reset -> c0 served first, grant = 1 on the next transaction, c1 served next, pointer back to c0.
REQ-036 TIMEOUT = 8, RAM never acks, c0 read -> c0ReadAck after 8 WAIT cycles with c0RData 0, timeoutErr = 1 until reset.
REQ-037 Reset asserted in WAIT, RAM readAck delivered 2 cycles after release -> all outputs 0, no client ack, state IDLE.
REQ-038 Both clients hold read requests for 20 transactions -> grants alternate 0,1,0,1..., each client receives 10 acks.
